// File: rtl/regfile_writeback_queue_if.sv
// Handshake and status bundle between the execute/memory producers, the RF
// write port and the operand-forwarding lookup of the write-back queue.
interface regfile_writeback_queue_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_dest;
    logic [XLEN-1:0]       alu_data;
    logic                  alu_ready;
    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_dest;
    logic [XLEN-1:0]       mem_data;
    logic                  mem_ready;
    logic                  rf_write_enable;
    logic [REG_ADDR_W-1:0] rf_dest;
    logic [XLEN-1:0]       rf_data_in;
    logic [REG_ADDR_W-1:0] src_one;
    logic [REG_ADDR_W-1:0] src_two;
    logic                  fwd_one_hit;
    logic [XLEN-1:0]       fwd_one_data;
    logic                  fwd_two_hit;
    logic [XLEN-1:0]       fwd_two_data;
    logic [CNT_W-1:0]      count;
    logic                  busy;

    modport master (
        output alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data, src_one, src_two,
        input  alu_ready, mem_ready, rf_write_enable, rf_dest, rf_data_in,
               fwd_one_hit, fwd_one_data, fwd_two_hit, fwd_two_data, count, busy
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data, src_one, src_two,
        output alu_ready, mem_ready, rf_write_enable, rf_dest, rf_data_in,
               fwd_one_hit, fwd_one_data, fwd_two_hit, fwd_two_data, count, busy
    );
endinterface

// File: rtl/regfile_writeback_queue.sv
// Write-back FIFO feeding the RF write port: mem-over-alu arbitration, one
// retire per cycle, and youngest-match forwarding for the two read addresses.
module regfile_writeback_queue #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 4
) (
    input logic                   clk,
    input logic                   reset,
    regfile_writeback_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    typedef struct packed {
        logic            hit;
        logic [XLEN-1:0] data;
    } fwd_t;

    wb_entry_t             fifo_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  rf_we_q;
    logic [REG_ADDR_W-1:0] rf_dest_q;
    logic [XLEN-1:0]       rf_data_q;

    logic      full, mem_acc, alu_acc, push, pop;
    wb_entry_t push_entry;
    fwd_t      fwd_one, fwd_two;

    // full comes from the registered count only, so a pop never frees a slot
    // for the same edge.
    assign full    = (count_q == CNT_W'(DEPTH));
    assign mem_acc = bus.mem_valid & ~full;
    assign alu_acc = bus.alu_valid & ~full & ~bus.mem_valid;
    assign pop     = (count_q != '0);

    always_comb begin
        push_entry = mem_acc ? {bus.mem_dest, bus.mem_data} : {bus.alu_dest, bus.alu_data};
        push       = (mem_acc | alu_acc) && (push_entry.dest != '0);
    end

    // Storage is deliberately unreset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= push_entry;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rf_we_q   <= 1'b0;
            rf_dest_q <= '0;
            rf_data_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rf_dest_q <= fifo_q[rd_ptr_q].dest;
                rf_data_q <= fifo_q[rd_ptr_q].data;
                rd_ptr_q  <= rd_ptr_q + 1'b1;
            end
            rf_we_q <= pop;
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Scan oldest to youngest (rf stage, then FIFO from rd_ptr) so the last match wins.
    function automatic fwd_t lookup(input logic [REG_ADDR_W-1:0] src);
        fwd_t             r;
        logic [PTR_W-1:0] idx;
        r = '0;
        if (rf_we_q && rf_dest_q == src) begin
            r.hit  = 1'b1;
            r.data = rf_data_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q && fifo_q[idx].dest == src) begin
                r.hit  = 1'b1;
                r.data = fifo_q[idx].data;
            end
        end
        if (src == '0) r = '0;
        return r;
    endfunction

    always_comb begin
        fwd_one = lookup(bus.src_one);
        fwd_two = lookup(bus.src_two);
    end

    assign bus.mem_ready       = ~full;
    assign bus.alu_ready       = ~full & ~bus.mem_valid;
    assign bus.rf_write_enable = rf_we_q;
    assign bus.rf_dest         = rf_dest_q;
    assign bus.rf_data_in      = rf_data_q;
    assign bus.fwd_one_hit     = fwd_one.hit;
    assign bus.fwd_one_data    = fwd_one.data;
    assign bus.fwd_two_hit     = fwd_two.hit;
    assign bus.fwd_two_data    = fwd_two.data;
    assign bus.count           = count_q;
    assign bus.busy            = (count_q != '0) | rf_we_q;
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for the write-back queue: arbitration, retire order,
// latency, dest==0 drop, forwarding and asynchronous reset.
module tb_regfile_writeback_queue;
    localparam int XLEN = 32, REG_ADDR_W = 5, DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    regfile_writeback_queue_if #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH)) bus ();

    regfile_writeback_queue #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0; bus.alu_dest = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_dest = '0; bus.mem_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.src_one = '0; bus.src_two = '0;
        #3;
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count); end
        total++; if (bus.rf_write_enable !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", bus.rf_write_enable); end
        total++; if (bus.rf_dest !== 5'd0 || bus.rf_data_in !== 32'd0) begin bad++; $display("FAIL reset_rf got=%0d/%h want=0/0", bus.rf_dest, bus.rf_data_in); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.src_one = 5'd5;
        bus.alu_valid = 1'b1; bus.alu_dest = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
        #1;
        total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", bus.alu_ready); end
        tick();
        idle_inputs();
        #1;
        total++; if (bus.count !== 3'd1 || bus.rf_write_enable !== 1'b0) begin bad++; $display("FAIL single_queued got=%0d/%b want=1/0", bus.count, bus.rf_write_enable); end
        total++; if (bus.fwd_one_hit !== 1'b1 || bus.fwd_one_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_fwd got=%b/%h want=1/deadbeef", bus.fwd_one_hit, bus.fwd_one_data); end
        tick();
        total++; if (bus.rf_write_enable !== 1'b1 || bus.rf_dest !== 5'd5 || bus.rf_data_in !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_write got=%b/%0d/%h want=1/5/deadbeef", bus.rf_write_enable, bus.rf_dest, bus.rf_data_in); end
        total++; if (bus.count !== 3'd0 || bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%0d/%b want=0/1", bus.count, bus.busy); end
        tick();
        total++; if (bus.rf_write_enable !== 1'b0 || bus.rf_dest !== 5'd5 || bus.busy !== 1'b0) begin bad++; $display("FAIL single_done got=%b/%0d/%b want=0/5/0", bus.rf_write_enable, bus.rf_dest, bus.busy); end
        bus.src_one = '0;
    endtask

    task automatic test_arbitration();
        bus.mem_valid = 1'b1; bus.mem_dest = 5'd3; bus.mem_data = 32'h11;
        bus.alu_valid = 1'b1; bus.alu_dest = 5'd4; bus.alu_data = 32'h22;
        #1;
        total++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin bad++; $display("FAIL arb_ready got=%b/%b want=1/0", bus.mem_ready, bus.alu_ready); end
        tick();
        bus.mem_valid = 1'b0;
        #1;
        total++; if (bus.alu_ready !== 1'b1 || bus.count !== 3'd1) begin bad++; $display("FAIL arb_alu_next got=%b/%0d want=1/1", bus.alu_ready, bus.count); end
        tick();
        idle_inputs();
        total++; if (bus.rf_write_enable !== 1'b1 || bus.rf_dest !== 5'd3 || bus.rf_data_in !== 32'h11) begin bad++; $display("FAIL arb_first got=%b/%0d/%h want=1/3/11", bus.rf_write_enable, bus.rf_dest, bus.rf_data_in); end
        total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL arb_pushpop_count got=%0d want=1", bus.count); end
        tick();
        total++; if (bus.rf_write_enable !== 1'b1 || bus.rf_dest !== 5'd4 || bus.rf_data_in !== 32'h22) begin bad++; $display("FAIL arb_second got=%b/%0d/%h want=1/4/22", bus.rf_write_enable, bus.rf_dest, bus.rf_data_in); end
        tick();
        total++; if (bus.rf_write_enable !== 1'b0 || bus.count !== 3'd0) begin bad++; $display("FAIL arb_drained got=%b/%0d want=0/0", bus.rf_write_enable, bus.count); end
    endtask

    task automatic test_back_to_back();
        logic [REG_ADDR_W-1:0] d;
        for (int i = 0; i < 5; i++) begin
            d = REG_ADDR_W'(10 + i);
            bus.alu_valid = 1'b1; bus.alu_dest = d; bus.alu_data = 32'h100 + i;
            #1;
            total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, bus.alu_ready); end
            tick();
            total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL b2b_count[%0d] got=%0d want=1", i, bus.count); end
            if (i > 0) begin
                total++;
                if (bus.rf_write_enable !== 1'b1 || bus.rf_dest !== REG_ADDR_W'(9 + i) || bus.rf_data_in !== 32'h100 + i - 1) begin
                    bad++; $display("FAIL b2b_order[%0d] got=%b/%0d/%h want=1/%0d/%h", i, bus.rf_write_enable, bus.rf_dest, bus.rf_data_in, 9 + i, 32'h100 + i - 1);
                end
            end
        end
        idle_inputs();
        tick();
        total++; if (bus.rf_write_enable !== 1'b1 || bus.rf_dest !== 5'd14 || bus.rf_data_in !== 32'h104) begin bad++; $display("FAIL b2b_last got=%b/%0d/%h want=1/14/104", bus.rf_write_enable, bus.rf_dest, bus.rf_data_in); end
        tick();
        total++; if (bus.rf_write_enable !== 1'b0 || bus.count !== 3'd0) begin bad++; $display("FAIL b2b_drained got=%b/%0d want=0/0", bus.rf_write_enable, bus.count); end
    endtask

    task automatic test_dest_zero();
        bus.src_one = 5'd0;
        bus.alu_valid = 1'b1; bus.alu_dest = 5'd0; bus.alu_data = 32'hFFFF_FFFF;
        #1;
        total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL zero_ready got=%b want=1", bus.alu_ready); end
        tick();
        idle_inputs();
        #1;
        total++; if (bus.count !== 3'd0 || bus.fwd_one_hit !== 1'b0 || bus.fwd_one_data !== 32'd0) begin bad++; $display("FAIL zero_dropped got=%0d/%b/%h want=0/0/0", bus.count, bus.fwd_one_hit, bus.fwd_one_data); end
        tick();
        total++; if (bus.rf_write_enable !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL zero_no_write got=%b/%b want=0/0", bus.rf_write_enable, bus.busy); end
    endtask

    task automatic test_forwarding();
        bus.src_one = 5'd7; bus.src_two = 5'd8;
        bus.alu_valid = 1'b1; bus.alu_dest = 5'd7; bus.alu_data = 32'hA;
        tick();
        bus.alu_data = 32'hB;
        #1;
        total++; if (bus.fwd_one_hit !== 1'b1 || bus.fwd_one_data !== 32'hA) begin bad++; $display("FAIL fwd_first got=%b/%h want=1/a", bus.fwd_one_hit, bus.fwd_one_data); end
        total++; if (bus.fwd_two_hit !== 1'b0 || bus.fwd_two_data !== 32'd0) begin bad++; $display("FAIL fwd_miss got=%b/%h want=0/0", bus.fwd_two_hit, bus.fwd_two_data); end
        tick();
        idle_inputs();
        #1;
        total++; if (bus.fwd_one_hit !== 1'b1 || bus.fwd_one_data !== 32'hB) begin bad++; $display("FAIL fwd_youngest got=%b/%h want=1/b", bus.fwd_one_hit, bus.fwd_one_data); end
        tick();
        total++; if (bus.fwd_one_hit !== 1'b1 || bus.fwd_one_data !== 32'hB || bus.rf_dest !== 5'd7) begin bad++; $display("FAIL fwd_rf_stage got=%b/%h/%0d want=1/b/7", bus.fwd_one_hit, bus.fwd_one_data, bus.rf_dest); end
        tick();
        total++; if (bus.fwd_one_hit !== 1'b0 || bus.fwd_one_data !== 32'd0) begin bad++; $display("FAIL fwd_retired got=%b/%h want=0/0", bus.fwd_one_hit, bus.fwd_one_data); end
    endtask

    task automatic test_reset_midrun();
        bus.src_one = 5'd21; bus.src_two = 5'd20;
        bus.alu_valid = 1'b1; bus.alu_dest = 5'd20; bus.alu_data = 32'h55;
        tick();
        bus.alu_dest = 5'd21; bus.alu_data = 32'h66;
        tick();
        idle_inputs();
        total++; if (bus.count !== 3'd1 || bus.rf_write_enable !== 1'b1 || bus.fwd_one_hit !== 1'b1 || bus.fwd_two_hit !== 1'b1) begin bad++; $display("FAIL mid_pending got=%0d/%b/%b/%b want=1/1/1/1", bus.count, bus.rf_write_enable, bus.fwd_one_hit, bus.fwd_two_hit); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (bus.rf_write_enable !== 1'b0 || bus.count !== 3'd0) begin bad++; $display("FAIL mid_reset_state got=%b/%0d want=0/0", bus.rf_write_enable, bus.count); end
        total++; if (bus.fwd_one_hit !== 1'b0 || bus.fwd_two_hit !== 1'b0) begin bad++; $display("FAIL mid_reset_fwd got=%b/%b want=0/0", bus.fwd_one_hit, bus.fwd_two_hit); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        total++; if (bus.rf_write_enable !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL mid_after got=%b/%b want=0/0", bus.rf_write_enable, bus.busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_arbitration();
        test_back_to_back();
        test_dest_zero();
        test_forwarding();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
